// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and counter sizing.
package reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_HOLD      = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // One spare bit so the terminal count compares without wrapping.
    function automatic int cnt_width(input int hold_cycles, input int stage_gap);
        int m;
        m = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Multi-flop synchroniser for an asynchronous level input, cleared by a synchronous reset.
module reset_seq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous level through the chain; the last flop is the safe copy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Ordered reset release: waits for stable PLL lock, then frees each downstream reset in turn.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_RST     = 3,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGE_GAP   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pll_locked_i,
    input  logic               soft_rst_i,
    output logic [NUM_RST-1:0] rst_o,
    output logic               ready_o,
    output logic               lock_lost_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    logic              w_locked;
    logic              w_abort;
    state_t            r_state;
    logic [CW-1:0]     r_hold_cnt;
    logic [CW-1:0]     r_gap_cnt;
    logic [IW-1:0]     r_idx;
    logic [NUM_RST-1:0] r_rst;
    logic              r_ready;
    logic              r_lock_lost;

    reset_seq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (w_locked)
    );

    assign w_abort = ~w_locked | soft_rst_i;

    // Sequencer FSM with its counters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_RESET;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_idx       <= '0;
            r_rst       <= '1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_lock_lost <= 1'b0;
            case (r_state)
                S_RESET: begin
                    r_state    <= S_WAIT_LOCK;
                    r_hold_cnt <= '0;
                    r_gap_cnt  <= '0;
                    r_idx      <= '0;
                end
                S_WAIT_LOCK: begin
                    r_rst   <= '1;
                    r_ready <= 1'b0;
                    if (w_locked && !soft_rst_i) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= '0;
                    end
                end
                S_HOLD: begin
                    if (w_abort) begin
                        r_state    <= S_WAIT_LOCK;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == CW'(HOLD_CYCLES - 1)) begin
                        r_rst[0]   <= 1'b0;
                        r_hold_cnt <= '0;
                        r_gap_cnt  <= '0;
                        r_idx      <= IW'(1);
                        if (NUM_RST == 1) begin
                            r_ready <= 1'b1;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (w_abort) begin
                        r_rst       <= '1;
                        r_ready     <= 1'b0;
                        r_lock_lost <= ~w_locked;
                        r_state     <= S_WAIT_LOCK;
                        r_gap_cnt   <= '0;
                        r_idx       <= '0;
                    end else if (r_gap_cnt == CW'(STAGE_GAP - 1)) begin
                        r_rst[r_idx] <= 1'b0;
                        r_gap_cnt    <= '0;
                        // The last bit going low completes the sequence on the same edge.
                        if (r_idx == IW'(NUM_RST - 1)) begin
                            r_ready <= 1'b1;
                            r_state <= S_RUN;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_rst       <= '1;
                        r_ready     <= 1'b0;
                        r_lock_lost <= ~w_locked;
                        r_state     <= S_WAIT_LOCK;
                    end else begin
                        r_rst   <= '0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_RESET;
                    r_rst      <= '1;
                    r_ready    <= 1'b0;
                    r_hold_cnt <= '0;
                    r_gap_cnt  <= '0;
                    r_idx      <= '0;
                end
            endcase
        end
    end

    assign rst_o       = r_rst;
    assign ready_o     = r_ready;
    assign lock_lost_o = r_lock_lost;
    assign state_o     = r_state;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: two configurations driven in lockstep, checked every cycle against a timeline model.
module tb_reset_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       soft_rst_i = 1'b0;

    logic [2:0] rst_a;
    logic       ready_a, lost_a;
    logic [2:0] state_a;
    logic [0:0] rst_b;
    logic       ready_b, lost_b;
    logic [2:0] state_b;

    int checks = 0;
    int failures = 0;

    // Model: per configuration, seq = edges since HOLD entry (-1 while waiting)
    int P_N[2] = '{3, 1};
    int P_H[2] = '{8, 1};
    int P_G[2] = '{4, 4};
    int seq[2];
    bit in_reset[2];
    bit lost[2];
    bit [1:0] msync[2];

    always #5 clk_i = ~clk_i;

    reset_seq #(.NUM_RST(3), .HOLD_CYCLES(8), .STAGE_GAP(4), .SYNC_STAGES(2)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .pll_locked_i(pll_locked_i), .soft_rst_i(soft_rst_i),
        .rst_o(rst_a), .ready_o(ready_a), .lock_lost_o(lost_a), .state_o(state_a)
    );

    reset_seq #(.NUM_RST(1), .HOLD_CYCLES(1), .STAGE_GAP(4), .SYNC_STAGES(2)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .pll_locked_i(pll_locked_i), .soft_rst_i(soft_rst_i),
        .rst_o(rst_b), .ready_o(ready_b), .lock_lost_o(lost_b), .state_o(state_b)
    );

    function automatic int final_t(input int d);
        return P_H[d] + (P_N[d] - 1) * P_G[d];
    endfunction

    function automatic logic [2:0] exp_rst(input int d);
        logic [2:0] v;
        v = 3'b000;
        for (int k = 0; k < P_N[d]; k++) begin
            v[k] = (seq[d] >= 0 && seq[d] >= P_H[d] + k * P_G[d]) ? 1'b0 : 1'b1;
        end
        return v;
    endfunction

    function automatic logic [2:0] exp_state(input int d);
        if (in_reset[d])              return 3'd0;
        else if (seq[d] < 0)          return 3'd1;
        else if (seq[d] >= final_t(d)) return 3'd4;
        else if (seq[d] >= P_H[d])    return 3'd3;
        else                          return 3'd2;
    endfunction

    task automatic model_edge(input int d, input logic r, input logic p, input logic s);
        bit ls;
        ls = msync[d][1];
        if (r) begin
            in_reset[d] = 1'b1;
            seq[d]      = -1;
            lost[d]     = 1'b0;
            msync[d]    = 2'b00;
        end else begin
            lost[d] = 1'b0;
            if (in_reset[d]) begin
                in_reset[d] = 1'b0;
            end else if (seq[d] < 0) begin
                if (ls && !s) seq[d] = 0;
            end else if (!ls || s) begin
                lost[d] = (seq[d] >= P_H[d]) && !ls;
                seq[d]  = -1;
            end else if (seq[d] < final_t(d)) begin
                seq[d]++;
            end
            msync[d] = {msync[d][0], p};
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_all();
        logic [2:0] ea;
        logic [2:0] eb;
        ea = exp_rst(0);
        eb = exp_rst(1);
        chk("a_rst_o", rst_a, ea);
        chk("a_ready_o", {2'b00, ready_a}, {2'b00, (!in_reset[0] && seq[0] >= final_t(0))});
        chk("a_lock_lost_o", {2'b00, lost_a}, {2'b00, lost[0]});
        chk("a_state_o", state_a, exp_state(0));
        chk("b_rst_o", {2'b00, rst_b}, {2'b00, eb[0]});
        chk("b_ready_o", {2'b00, ready_b}, {2'b00, (!in_reset[1] && seq[1] >= final_t(1))});
        chk("b_lock_lost_o", {2'b00, lost_b}, {2'b00, lost[1]});
        chk("b_state_o", state_b, exp_state(1));
    endtask

    task automatic step(input logic r, input logic p, input logic s);
        rst_i        = r;
        pll_locked_i = p;
        soft_rst_i   = s;
        @(posedge clk_i);
        model_edge(0, r, p, s);
        model_edge(1, r, p, s);
        #1;
        check_all();
    endtask

    task automatic run(input int n, input logic r, input logic p, input logic s);
        for (int i = 0; i < n; i++) step(r, p, s);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            seq[d] = -1; in_reset[d] = 1'b1; lost[d] = 1'b0; msync[d] = 2'b00;
        end
        // Scenario 1: clean power-up with lock already high; B shows NUM_RST=1 at E3
        run(2, 1'b1, 1'b1, 1'b0);
        run(25, 1'b0, 1'b1, 1'b0);
        checks++;
        assert (rst_a === 3'b000 && ready_a === 1'b1 && state_a === 3'd4) else begin
            failures++;
            $error("FAIL s1_run observed=%b/%b/%0d expected=000/1/4", rst_a, ready_a, state_a);
        end
        // Scenario 2: lock dropout in HOLD after 6 counted cycles
        run(2, 1'b1, 1'b1, 1'b0);
        run(8, 1'b0, 1'b1, 1'b0);
        run(5, 1'b0, 1'b0, 1'b0);
        run(30, 1'b0, 1'b1, 1'b0);
        // Scenario 3: lock lost while running, then relock
        run(3, 1'b0, 1'b0, 1'b0);
        run(30, 1'b0, 1'b1, 1'b0);
        // Scenario 4: software reset between bit-0 and bit-1 releases
        run(2, 1'b1, 1'b1, 1'b0);
        run(12, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        run(30, 1'b0, 1'b1, 1'b0);
        // Scenario 5: one-cycle rst_i in the middle of RELEASE
        run(2, 1'b1, 1'b1, 1'b0);
        run(15, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        run(25, 1'b0, 1'b1, 1'b0);
        // Random phase: sporadic resets, soft requests and lock toggles
        begin
            logic p;
            p = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 39) == 0) p = ~p;
                step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, p,
                     ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
